// File: rtl/bucket_header_unpacker_pkg.sv
// Bucket layout helpers shared by the header unpacker and its counters.
package bucket_header_unpacker_pkg;

  typedef struct packed {
    int unsigned hv;
    int unsigned hu;
    int unsigned hl;
    int unsigned hh;
    int unsigned hdr_chunks;
    int unsigned bkt_chunks;
    int unsigned path_payload;
  } layout_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Header field bases: IV, then valid bits, PAddrs, leaves and MACs.
  function automatic layout_t hdr_layout(input int unsigned bed_width,
                                         input int unsigned z,
                                         input int unsigned u,
                                         input int unsigned l,
                                         input int unsigned h,
                                         input int unsigned entropy,
                                         input int unsigned blk_chunks);
    layout_t lay;
    lay.hv           = entropy;
    lay.hu           = lay.hv + z;
    lay.hl           = lay.hu + z * u;
    lay.hh           = lay.hl + z * l;
    lay.hdr_chunks   = (lay.hh + z * h + bed_width - 1) / bed_width;
    lay.bkt_chunks   = lay.hdr_chunks + z * blk_chunks;
    lay.path_payload = (l + 1) * z * blk_chunks;
    return lay;
  endfunction

endpackage

// File: rtl/bucket_header_unpacker_beat_counter.sv
// Wrapping beat counter; Done flags the enabled beat at Threshold-1.
module bucket_header_unpacker_beat_counter
  import bucket_header_unpacker_pkg::*;
#(
  parameter int unsigned Threshold = 2,
  localparam int unsigned W = cnt_width(Threshold)
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Enable,
  output logic [W-1:0] Count,
  output logic         Done
);

  assign Done = Enable && (Count == W'(Threshold - 1));

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Count <= '0;
    end else if (Enable) begin
      Count <= Done ? '0 : Count + 1'b1;
    end
  end

endmodule

// File: rtl/bucket_header_unpacker.sv
// Splits DRAM bucket chunks into header capture and per-block stash beats
// tagged with the block's PAddr, leaf and MAC.
module bucket_header_unpacker
  import bucket_header_unpacker_pkg::*;
#(
  parameter int unsigned BEDWidth   = 512,
  parameter int unsigned ORAMZ      = 4,
  parameter int unsigned ORAMU      = 32,
  parameter int unsigned ORAML      = 32,
  parameter int unsigned ORAMH      = 64,
  parameter int unsigned AESEntropy = 64,
  parameter int unsigned BlkChunks  = 1,
  parameter bit          EnableAES  = 1'b1,
  parameter logic [AESEntropy-1:0] IVINIT = '0,
  parameter bit          EnableIV   = 1'b1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [BEDWidth-1:0] DRAMData,
  input  logic                DRAMValid,
  output logic                DRAMReady,
  output logic [BEDWidth-1:0] StashData,
  output logic                StashValid,
  input  logic                StashReady,
  output logic [ORAMU-1:0]    StashPAddr,
  output logic [ORAML-1:0]    StashLeaf,
  output logic [ORAMH-1:0]    StashMAC,
  output logic                PathTransition
);

  localparam layout_t Lay = hdr_layout(BEDWidth, ORAMZ, ORAMU, ORAML, ORAMH,
                                       AESEntropy, BlkChunks);
  localparam int unsigned HV          = Lay.hv;
  localparam int unsigned HU          = Lay.hu;
  localparam int unsigned HL          = Lay.hl;
  localparam int unsigned HH          = Lay.hh;
  localparam int unsigned HdrChunks   = Lay.hdr_chunks;
  localparam int unsigned BktChunks   = Lay.bkt_chunks;
  localparam int unsigned PathPayload = Lay.path_payload;
  localparam int unsigned HdrBits     = HdrChunks * BEDWidth;
  localparam int unsigned HdrUsed     = HH + ORAMZ * ORAMH;
  localparam int unsigned BcW         = cnt_width(BktChunks);
  localparam int unsigned BlkW        = cnt_width(BlkChunks);
  localparam int unsigned SlotW       = cnt_width(ORAMZ);
  localparam int unsigned PathW       = cnt_width(PathPayload);

  logic               beat, payload_valid, payload_beat;
  logic               bucket_end, block_end, slot_done, path_done;
  logic               header_full, bucket_valid, slot_v;
  logic [BcW-1:0]     bucket_count;
  logic [BlkW-1:0]    blk_count;
  logic [SlotW-1:0]   cb, slot;
  logic [PathW-1:0]   path_count;
  logic [HdrBits-1:0] hdr;
  logic [ORAMH-1:0]   slot_mac;
  logic               unused_bits;

  assign DRAMReady     = StashReady;
  assign StashData     = DRAMData;
  assign beat          = DRAMValid && StashReady;
  assign payload_valid = DRAMValid && header_full;
  assign payload_beat  = payload_valid && StashReady;

  bucket_header_unpacker_beat_counter #(.Threshold(BktChunks)) u_bucket (
    .Clock(Clock), .Reset(Reset), .Enable(beat),
    .Count(bucket_count), .Done(bucket_end)
  );

  bucket_header_unpacker_beat_counter #(.Threshold(BlkChunks)) u_block (
    .Clock(Clock), .Reset(Reset), .Enable(payload_beat),
    .Count(blk_count), .Done(block_end)
  );

  bucket_header_unpacker_beat_counter #(.Threshold(ORAMZ)) u_slot (
    .Clock(Clock), .Reset(Reset), .Enable(block_end),
    .Count(cb), .Done(slot_done)
  );

  bucket_header_unpacker_beat_counter #(.Threshold(PathPayload)) u_path (
    .Clock(Clock), .Reset(Reset), .Enable(payload_beat),
    .Count(path_count), .Done(path_done)
  );

  // Header chunk k is stored at chunk position k, so the bucket beat count
  // doubles as the write index while the header is filling.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      hdr         <= '0;
      header_full <= 1'b0;
    end else if (beat) begin
      if (bucket_end) begin
        header_full <= 1'b0;
      end else if (!header_full) begin
        for (int unsigned k = 0; k < HdrChunks; k++) begin
          if (bucket_count == BcW'(k)) hdr[k*BEDWidth +: BEDWidth] <= DRAMData;
        end
        if (bucket_count == BcW'(HdrChunks - 1)) header_full <= 1'b1;
      end
    end
  end

  // Blocks arrive in reverse slot order.
  assign slot = SlotW'(ORAMZ - 1) - cb;

  always_comb begin
    slot_v     = 1'b0;
    StashPAddr = '0;
    StashLeaf  = '0;
    slot_mac   = '0;
    for (int unsigned s = 0; s < ORAMZ; s++) begin
      if (slot == SlotW'(s)) begin
        slot_v     = hdr[HV+s];
        StashPAddr = hdr[HU+s*ORAMU +: ORAMU];
        StashLeaf  = hdr[HL+s*ORAML +: ORAML];
        slot_mac   = hdr[HH+s*ORAMH +: ORAMH];
      end
    end
  end

  assign bucket_valid   = EnableAES ? (hdr[AESEntropy-1:0] != IVINIT) : 1'b1;
  assign StashValid     = payload_valid && slot_v && bucket_valid;
  assign StashMAC       = EnableIV ? slot_mac : '0;
  assign PathTransition = path_done;

  assign unused_bits = ^{blk_count, path_count, slot_done, hdr[HdrBits-1:HdrUsed]};

endmodule

// File: tb/tb_bucket_header_unpacker.sv
// Scoreboard bench: stimulus pushes per-beat expectations built from the
// bucket layout; a negedge monitor pops and compares on every accepted beat.
module tb_bucket_header_unpacker;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic [511:0] DRAMData = '0;
  logic         DRAMValid = 1'b0;
  logic         DRAMReady;
  logic [511:0] StashData;
  logic         StashValid;
  logic         StashReady = 1'b0;
  logic [31:0]  StashPAddr;
  logic [31:0]  StashLeaf;
  logic [63:0]  StashMAC;
  logic         PathTransition;

  always #5 Clock = ~Clock;

  bucket_header_unpacker #(
    .BEDWidth(512), .ORAMZ(4), .ORAMU(32), .ORAML(32), .ORAMH(64),
    .AESEntropy(64), .BlkChunks(1), .EnableAES(1'b1), .EnableIV(1'b1)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .DRAMData(DRAMData), .DRAMValid(DRAMValid), .DRAMReady(DRAMReady),
    .StashData(StashData), .StashValid(StashValid), .StashReady(StashReady),
    .StashPAddr(StashPAddr), .StashLeaf(StashLeaf), .StashMAC(StashMAC),
    .PathTransition(PathTransition)
  );

  typedef struct packed {
    logic         hdr_beat;
    logic         sv;
    logic [31:0]  pa;
    logic [31:0]  lf;
    logic [63:0]  mc;
    logic [511:0] data;
    logic         pt;
  } exp_t;

  typedef struct packed {
    logic [63:0]       iv;
    logic [3:0]        v;
    logic [3:0][31:0]  pa;
    logic [3:0][31:0]  lf;
    logic [3:0][63:0]  mc;
    logic [3:0][511:0] pl;
  } bucket_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int path_pos = 0;
  int pulses_seen = 0;
  int pulses_exp = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Header layout: IV[63:0], valid[67:64], PAddr 68+32s, leaf 196+32s, MAC 324+64s.
  function automatic logic [1023:0] pack_hdr(input bucket_t b);
    logic [1023:0] h;
    h = '0;
    h[63:0] = b.iv;
    for (int s = 0; s < 4; s++) begin
      h[64+s]          = b.v[s];
      h[68+32*s +: 32]  = b.pa[s];
      h[196+32*s +: 32] = b.lf[s];
      h[324+64*s +: 64] = b.mc[s];
    end
    return h;
  endfunction

  function automatic bucket_t rnd_bucket();
    bucket_t b;
    b.iv = ($urandom_range(3) == 0) ? 64'd0 : {$urandom, $urandom};
    b.v  = 4'($urandom);
    for (int s = 0; s < 4; s++) begin
      b.pa[s] = $urandom;
      b.lf[s] = $urandom;
      b.mc[s] = {$urandom, $urandom};
      b.pl[s] = rnd512();
    end
    return b;
  endfunction

  task automatic issue(input logic [511:0] data, input exp_t e,
                       input int stall_pct, input int idle_pct, input int fixed_stall);
    int n_idle, n_stall;
    n_idle  = ($urandom_range(99) < idle_pct) ? $urandom_range(1, 3) : 0;
    n_stall = ($urandom_range(99) < stall_pct) ? $urandom_range(1, 3) : 0;
    n_stall += fixed_stall;
    repeat (n_idle) begin
      DRAMValid = 1'b0; DRAMData = rnd512(); StashReady = 1'($urandom);
      @(posedge Clock); #1;
    end
    repeat (n_stall) begin
      DRAMValid = 1'b1; DRAMData = data; StashReady = 1'b0;
      @(posedge Clock); #1;
    end
    DRAMValid = 1'b1; DRAMData = data; StashReady = 1'b1;
    sb.push_back(e);
    if (e.pt) pulses_exp++;
    @(posedge Clock); #1;
  endtask

  task automatic send_bucket(input bucket_t b, input int stall_pct, input int idle_pct,
                             input int stall_at);
    logic [1023:0] h;
    exp_t e;
    int slot;
    h = pack_hdr(b);
    for (int c = 0; c < 2; c++) begin
      e = '0;
      e.hdr_beat = 1'b1;
      e.data = h[c*512 +: 512];
      issue(e.data, e, stall_pct, idle_pct, 0);
    end
    for (int j = 0; j < 4; j++) begin
      slot = 3 - j;
      e = '0;
      e.sv   = b.v[slot] && (b.iv != 64'd0);
      e.pa   = b.pa[slot];
      e.lf   = b.lf[slot];
      e.mc   = b.mc[slot];
      e.data = b.pl[j];
      e.pt   = (path_pos == 131);
      path_pos = (path_pos + 1) % 132;
      issue(e.data, e, stall_pct, idle_pct, (j == stall_at) ? 3 : 0);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0; DRAMValid = 1'b0; StashReady = 1'b0;
    @(posedge Clock); #1;
    DRAMValid = 1'b1; DRAMData = rnd512(); StashReady = 1'b1;
    @(negedge Clock);
    chk("reset_stash_valid", 512'(StashValid), 512'(1'b0));
    chk("reset_path_transition", 512'(PathTransition), 512'(1'b0));
    @(posedge Clock); #1;
    Reset = 1'b1; DRAMValid = 1'b0; StashReady = 1'b0;
    sb.delete();
    path_pos = 0;
  endtask

  always @(negedge Clock) begin
    exp_t e;
    if (Reset) begin
      chk("dram_ready", 512'(DRAMReady), 512'(StashReady));
      if (PathTransition) pulses_seen++;
      if (DRAMValid && StashReady) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_beat: got a beat, expected none at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("stash_data", StashData, e.data);
          chk("stash_valid", 512'(StashValid), 512'(e.sv));
          chk("path_transition", 512'(PathTransition), 512'(e.pt));
          if (!e.hdr_beat) begin
            chk("stash_paddr", 512'(StashPAddr), 512'(e.pa));
            chk("stash_leaf", 512'(StashLeaf), 512'(e.lf));
            chk("stash_mac", 512'(StashMAC), 512'(e.mc));
          end
        end
      end else begin
        chk("idle_path_transition", 512'(PathTransition), 512'(1'b0));
        if (!DRAMValid) chk("idle_stash_valid", 512'(StashValid), 512'(1'b0));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bucket_t a, b;
    exp_t e;
    logic [1023:0] h;

    do_reset();

    // Directed bucket: IV=5, V=1010, slots s -> PAddr 0x10+s.
    a.iv = 64'd5;
    a.v  = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      a.pa[s] = 32'h10 + 32'(s);
      a.lf[s] = 32'h20 + 32'(s);
      a.mc[s] = 64'h30 + 64'(s);
      a.pl[s] = rnd512();
    end
    send_bucket(a, 0, 0, -1);

    b = a;
    b.iv = 64'd0;
    send_bucket(b, 0, 0, -1);

    // Three-cycle stall before the third payload beat.
    send_bucket(a, 0, 0, 2);

    // Reset after one header chunk; the next bucket must rebuild the header.
    b = rnd_bucket();
    h = pack_hdr(b);
    e = '0;
    e.hdr_beat = 1'b1;
    e.data = h[511:0];
    issue(e.data, e, 0, 0, 0);
    do_reset();
    b = rnd_bucket();
    b.iv = 64'd7;
    b.v  = 4'b1111;
    send_bucket(b, 0, 0, -1);

    // Full path plus one bucket, back to back.
    do_reset();
    for (int i = 0; i < 34; i++) send_bucket(rnd_bucket(), 0, 0, -1);

    // Random buckets with stalls and idle gaps.
    for (int i = 0; i < 40; i++) send_bucket(rnd_bucket(), 20, 20, -1);

    DRAMValid = 1'b0; StashReady = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    chk("queue_empty", 512'(sb.size()), 512'(0));
    chk("pulse_count", 512'(pulses_seen), 512'(pulses_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bucket_header_unpacker.md
Name: bucket_header_unpacker

Overview:
- Converts the DRAM read stream of bucket chunks into the stash's per-block stream.
- DRAM bucket format: header chunks {IV, valid bits, PAddrs, leaves, MACs}, followed by Z blocks of payload chunks.
- Stash format: each payload chunk paired with its block's PAddr, leaf and MAC, plus a validity qualifier.
- Sits between the DRAM read path and the stash; also flags the end of each path read.

Parameters:
- BEDWidth, 512, DRAM/stash chunk width.
- ORAMZ, 4, blocks per bucket.
- ORAMU, 32, PAddr width.
- ORAML, 32, leaf width; a path has ORAML+1 buckets.
- ORAMH, 64, per-block MAC width.
- AESEntropy, 64, IV width.
- BlkChunks, 1, payload chunks per block.
- EnableAES, 1, gate blocks on IV != IVINIT.
- IVINIT, 0, IV value of a never-written bucket.
- EnableIV, 1, drive StashMAC from the header.

Derived constants:
- HV = AESEntropy
- HU = HV + Z
- HL = HU + Z·U
- HH = HL + Z·L
- HdrChunks = ceil((HH + Z·H) / BEDWidth); defaults give 2.
- BktChunks = HdrChunks + Z·BlkChunks
- PathPayload = (L+1)·Z·BlkChunks

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- DRAMData  in  BEDWidth  chunk from DRAM.
- DRAMValid  in  1  chunk valid.
- DRAMReady  out  1  equals StashReady.
- StashData  out  BEDWidth  equals DRAMData.
- StashValid  out  1  real payload chunk present.
- StashReady  in  1  stash accepts.
- StashPAddr  out  ORAMU  PAddr of the current block.
- StashLeaf  out  ORAML  leaf of the current block.
- StashMAC  out  ORAMH  MAC of the current block; 0 when EnableIV=0.
- PathTransition  out  1  one-cycle pulse on the last payload beat of a path.

Behaviour:
- A beat is a cycle with DRAMValid && DRAMReady; DRAMReady = StashReady (combinational).
- Bucket beat counter:
  - Range 0..BktChunks-1; increments per beat.
  - BucketEnd = the beat at count BktChunks-1; the counter wraps to 0 after it.
- Header register:
  - While not full and not BucketEnd, each beat shifts DRAMData in.
  - First chunk lands in bits [BEDWidth-1:0], the k-th chunk in [(k+1)·BEDWidth-1 : k·BEDWidth].
  - HeaderFull is set when HdrChunks chunks have been captured; no further shifting while full.
  - HeaderFull clears on the cycle after the BucketEnd beat, ready for the next bucket.
- PayloadValid = DRAMValid && HeaderFull.
- Block/slot counters:
  - Within-block counter counts PayloadValid && StashReady beats, modulo BlkChunks; its wrap is BlockEnd.
  - Block counter CB (0..Z-1) increments on BlockEnd and wraps to 0.
  - Slot = Z-1-CB, so the first block in a bucket uses header slot Z-1 (reversed order).
- Slot fields, slot s:
  - V = hdr[HV+s]
  - U = hdr[HU+s·U +: U]
  - L = hdr[HL+s·L +: L]
  - H = hdr[HH+s·H +: H]
- Outputs:
  - BucketValid = EnableAES ? (IV != IVINIT) : 1, where IV = hdr[AESEntropy-1:0].
  - StashValid = PayloadValid && V && BucketValid.
  - StashData, StashPAddr, StashLeaf and StashMAC are combinational from the current input chunk and the header register; latency 0.
- Path counter:
  - Counts PayloadValid && StashReady beats.
  - PathTransition is asserted combinationally on the beat where the count equals PathPayload-1; the counter then wraps.
- Reset (Reset=0 at a clock edge):
  - All counters go to 0, HeaderFull=0, header register to 0.
  - Outputs: StashValid=0, PathTransition=0.
  - Reset mid-bucket discards the partial header.
- StashReady=0 stalls every counter and the shifter; all state holds.
- Header beats never produce StashValid.

Decomposition:
- Shared package: derived offsets HV/HU/HL/HH, HdrChunks, BktChunks, PathPayload, and a log2 helper for counter widths.
- One natural sub-module: beat_counter.
  - Parameter Threshold; inputs Clock, Reset, Enable.
  - Outputs Count and Done, where Done = Enable && Count == Threshold-1 and the count wraps to 0.
  - Instantiated 4 times: bucket, block, slot, path.

Test Plan:
- Bucket with IV=5, V=4'b1010, PAddr slots {s0=0x10, s1=0x11, s2=0x12, s3=0x13}, leaves similar, StashReady=1 -> no StashValid on the 2 header beats; payload beats report PAddr 0x13, 0x12, 0x11, 0x10 with StashValid 1, 0, 1, 0.
- Same bucket with IV=0 (EnableAES=1) -> StashValid=0 for all 4 payload beats; PAddr/leaf still track slots.
- StashReady held 0 for 3 cycles mid-payload -> DRAMReady=0; no counter advance; the resumed beat carries the same slot's PAddr.
- Stream a full path of 33 buckets (198 beats) -> PathTransition pulses once, on beat 198 (last payload of bucket 33); the next bucket's header begins cleanly.
- Reset=0 asserted after 1 header chunk, then a fresh bucket -> header rebuilt from the new chunks; the first payload beat uses the new bucket's slot-3 fields.
- Back-to-back buckets with no idle cycles -> the second bucket's header is captured correctly on the beat after BucketEnd.
